// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory.
//   SZ_*          : access size encodings on the size port (2'b11 behaves as word)
//   state_t       : sweep/service FSM states
//   BASE_ADDR_DEF : default byte address of word 0
package dmem_pkg;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h1001_0000;

  typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} state_t;
endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic for one access.
//   size, offset : access size and byte offset (addr[1:0])
//   sign_ext     : load extension mode
//   wdata        : right-aligned store data
//   rword        : raw word read from the array
//   be, wword    : store byte enables and lane-replicated store word
//   rdata        : extracted and extended load data
//   misalign     : access is not naturally aligned for its size
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic [7:0]  lane8;
  logic [15:0] lane16;

  assign lane8  = rword[{offset, 3'b000} +: 8];
  assign lane16 = rword[{offset[1], 4'b0000} +: 16];

  // Store data is replicated across lanes; the byte enables pick the live copy.
  always_comb begin
    be       = 4'hF;
    wword    = wdata;
    rdata    = rword;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << offset;
        wword = {4{wdata[7:0]}};
        rdata = {{24{sign_ext & lane8[7]}}, lane8};
      end
      SZ_HALF: begin
        misalign = offset[0];
        be       = 4'b0011 << offset;
        wword    = {2{wdata[15:0]}};
        rdata    = {{16{sign_ext & lane16[15]}}, lane16};
      end
      default: misalign = |offset;   // word and reserved encoding
    endcase
  end
endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory for the MEM stage.
//   clk, rst          : clock, asynchronous active-low reset
//   ena, wena         : request strobe, 1 = store / 0 = load
//   size, sign_ext    : access size, load extension mode
//   addr_in, data_in  : store address and right-aligned store data
//   addr_out          : load address
//   data_out, rvalid  : registered load result and its one-cycle valid
//   ready             : array cleared and accepting requests
//   misalign, oob     : one-cycle error pulses for the previous request
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2     = 10,
  parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEF,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        wena,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr_in,
  input  logic [31:0] addr_out,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rvalid,
  output logic        ready,
  output logic        misalign,
  output logic        oob
);
  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [31:0] DEPTH32 = 32'(DEPTH);

  logic [31:0]           mem [DEPTH];
  state_t                state;
  logic [DEPTH_LOG2-1:0] cnt;

  logic [31:0]           acc_addr, widx, rword, wword, rdata;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            be;
  logic                  acc, bad_mis, bad_oob, st_ok;

  // A request uses the store or load address depending on its direction.
  assign acc_addr = wena ? addr_in : addr_out;
  // Unsigned subtract: addresses below BASE_ADDR wrap to huge indices -> oob.
  assign widx     = (acc_addr - BASE_ADDR) >> 2;
  assign bad_oob  = widx >= DEPTH32;
  assign idx      = widx[DEPTH_LOG2-1:0];
  assign rword    = mem[idx];

  assign acc   = ena & ready;
  assign st_ok = acc & wena & ~bad_mis & ~bad_oob;

  dmem_align u_align (
    .size     (size),
    .offset   (acc_addr[1:0]),
    .sign_ext (sign_ext),
    .wdata    (data_in),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (rdata),
    .misalign (bad_mis)
  );

  // Array has no reset; the sweep clears it one word per cycle.
  always_ff @(posedge clk) begin
    if (state == SWEEP)
      mem[cnt] <= '0;
    else if (st_ok)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
  end

  // FSM and output registers. ready follows state by one cycle, so the
  // sweep adds exactly DEPTH cycles before ready compared to no sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR_ON_RESET ? SWEEP : IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      data_out <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      oob      <= 1'b0;
    end else begin
      rvalid   <= acc & ~wena;
      misalign <= acc & bad_mis;
      oob      <= acc & bad_oob;
      if (acc && !wena)
        data_out <= (bad_mis || bad_oob) ? '0 : rdata;
      case (state)
        SWEEP: begin
          cnt <= cnt + 1'b1;
          if (&cnt) state <= IDLE;
        end
        default: ready <= 1'b1;
      endcase
    end
  end
endmodule
